// File: rtl/bbox_tracker.sv
// Colour-threshold bounding-box tracker on an Avalon-ST RGB stream.
// Beats pass through a one-entry register slice; matching pixels grow a per-frame box exposed over Avalon-MM.
module bbox_tracker #(
  parameter int IMAGE_W = 640,
  parameter int IMAGE_H = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] sink_data,
  input  logic        sink_valid,
  input  logic        sink_sop,
  input  logic        sink_eop,
  output logic        sink_ready,
  output logic [23:0] source_data,
  output logic        source_valid,
  output logic        source_sop,
  output logic        source_eop,
  input  logic        source_ready,
  input  logic        s_chipselect,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [2:0]  s_address,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata
);
  typedef enum logic [1:0] {WAIT_SOP, VIDEO, OTHER} state_t;

  localparam logic [10:0] X_LAST    = 11'(IMAGE_W - 1);
  localparam logic [10:0] Y_LIMIT   = 11'(IMAGE_H);
  localparam logic [19:0] COUNT_MAX = 20'hFFFFF;

  state_t      state, state_next;
  logic        accept, frame_start, pixel_en, frame_end, in_range, match;
  logic        csr_write, done_clear, hit, done;
  logic [10:0] x, y, xmin, ymin, xmax, ymax;
  logic [10:0] xmin_next, ymin_next, xmax_next, ymax_next;
  logic [10:0] res_xmin, res_ymin, res_xmax, res_ymax;
  logic [19:0] count, count_next, res_count;
  logic [15:0] frame_count;
  logic [23:0] lo, hi;
  logic [31:0] read_mux;
  logic        unused_bits;

  assign sink_ready  = source_ready || !source_valid;
  assign accept      = sink_valid && sink_ready;
  assign csr_write   = s_chipselect && s_write;
  assign done_clear  = csr_write && (s_address == 3'd0) && s_writedata[1];
  assign unused_bits = ^s_writedata[31:24];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_data  <= '0;
    end else if (accept) begin
      source_valid <= 1'b1;
      source_sop   <= sink_sop;
      source_eop   <= sink_eop;
      source_data  <= sink_data;
    end else if (source_ready) begin
      source_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= WAIT_SOP;
    else          state <= state_next;
  end

  // Any sop restarts parsing, so a truncated frame is simply dropped.
  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    pixel_en    = 1'b0;
    frame_end   = 1'b0;
    if (accept) begin
      if (sink_sop) begin
        frame_start = 1'b1;
        if (sink_eop)                  state_next = WAIT_SOP;
        else if (sink_data[3:0] == '0) state_next = VIDEO;
        else                           state_next = OTHER;
      end else begin
        if (state == VIDEO) begin
          pixel_en  = 1'b1;
          frame_end = sink_eop;
        end
        if (sink_eop) state_next = WAIT_SOP;
      end
    end
  end

  assign in_range = (sink_data[23:16] >= lo[23:16]) && (sink_data[23:16] <= hi[23:16]) &&
                    (sink_data[15:8]  >= lo[15:8])  && (sink_data[15:8]  <= hi[15:8])  &&
                    (sink_data[7:0]   >= lo[7:0])   && (sink_data[7:0]   <= hi[7:0]);
  assign match    = pixel_en && (y < Y_LIMIT) && in_range;

  // A zero count marks the first match of the frame, which seeds the box.
  always_comb begin
    xmin_next  = xmin;
    ymin_next  = ymin;
    xmax_next  = xmax;
    ymax_next  = ymax;
    count_next = count;
    if (match) begin
      if (count == '0) begin
        xmin_next = x;
        xmax_next = x;
        ymin_next = y;
        ymax_next = y;
      end else begin
        if (x < xmin) xmin_next = x;
        if (x > xmax) xmax_next = x;
        if (y < ymin) ymin_next = y;
        if (y > ymax) ymax_next = y;
      end
      if (count != COUNT_MAX) count_next = count + 20'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || frame_start) begin
      x     <= '0;
      y     <= '0;
      xmin  <= '0;
      ymin  <= '0;
      xmax  <= '0;
      ymax  <= '0;
      count <= '0;
    end else if (pixel_en) begin
      xmin  <= xmin_next;
      ymin  <= ymin_next;
      xmax  <= xmax_next;
      ymax  <= ymax_next;
      count <= count_next;
      if (x == X_LAST) begin
        x <= '0;
        y <= y + 11'd1;
      end else begin
        x <= x + 11'd1;
      end
    end
  end

  // The eop pixel itself is folded in, hence the *_next values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      res_xmin    <= '0;
      res_ymin    <= '0;
      res_xmax    <= '0;
      res_ymax    <= '0;
      res_count   <= '0;
      hit         <= 1'b0;
      done        <= 1'b0;
      frame_count <= '0;
    end else if (frame_end) begin
      res_xmin    <= xmin_next;
      res_ymin    <= ymin_next;
      res_xmax    <= xmax_next;
      res_ymax    <= ymax_next;
      res_count   <= count_next;
      hit         <= (count_next != '0);
      done        <= 1'b1;
      frame_count <= frame_count + 16'd1;
    end else if (done_clear) begin
      done <= 1'b0;
    end
  end

  always_comb begin
    read_mux = '0;
    case (s_address)
      3'd0:    read_mux = {frame_count, 14'b0, done, hit};
      3'd1:    read_mux = {5'b0, res_ymin, 5'b0, res_xmin};
      3'd2:    read_mux = {5'b0, res_ymax, 5'b0, res_xmax};
      3'd3:    read_mux = {12'b0, res_count};
      3'd4:    read_mux = {8'b0, lo};
      3'd5:    read_mux = {8'b0, hi};
      3'd6:    read_mux = 32'h00BB0001;
      default: read_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lo         <= 24'h000000;
      hi         <= 24'hFFFFFF;
      s_readdata <= '0;
    end else begin
      if (csr_write && s_address == 3'd4) lo <= s_writedata[23:0];
      if (csr_write && s_address == 3'd5) hi <= s_writedata[23:0];
      if (s_chipselect && s_read) s_readdata <= read_mux;
    end
  end
endmodule

// File: tb/tb_bbox_tracker.sv
// Randomized bench for bbox_tracker: stream scoreboard plus an index-based reference model of the box.
module tb_bbox_tracker;
  localparam int W = 4;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] sink_data = '0;
  logic        sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0;
  logic        sink_ready;
  logic [23:0] source_data;
  logic        source_valid, source_sop, source_eop;
  logic        source_ready = 1'b1;
  logic        s_chipselect = 1'b0, s_read = 1'b0, s_write = 1'b0;
  logic [2:0]  s_address = '0;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;

  int          checks = 0;
  int          failures = 0;
  bit          randomReady = 1'b0;
  logic [25:0] expQ[$];
  logic [25:0] expBeat;
  int          expFrames = 0;
  bit          expDone = 1'b0;
  logic [23:0] curLo = 24'h000000, curHi = 24'hFFFFFF;
  logic [10:0] mXmin, mYmin, mXmax, mYmax;
  logic [19:0] mCount;
  logic [23:0] frame[$];
  logic [31:0] rd;

  bbox_tracker #(.IMAGE_W(W), .IMAGE_H(H)) dut (
    .clk(clk), .reset_n(reset_n),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_ready(sink_ready),
    .source_data(source_data), .source_valid(source_valid), .source_sop(source_sop),
    .source_eop(source_eop), .source_ready(source_ready),
    .s_chipselect(s_chipselect), .s_read(s_read), .s_write(s_write), .s_address(s_address),
    .s_writedata(s_writedata), .s_readdata(s_readdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) source_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  // Every completed source beat must be the oldest accepted sink beat.
  always @(negedge clk) begin
    #2;
    if (reset_n && source_valid && source_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_beat", 32'h1, 32'h0);
      end else begin
        expBeat = expQ.pop_front();
        checkOutput("stream_beat", {6'b0, source_sop, source_eop, source_data}, {6'b0, expBeat});
      end
    end
  end

  function automatic logic [7:0] pal(input int i);
    case (i)
      0:       return 8'h00;
      1:       return 8'h40;
      2:       return 8'h80;
      3:       return 8'hC0;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic bit pixelMatches(input logic [23:0] p, input logic [23:0] lo, input logic [23:0] hi);
    for (int c = 0; c < 3; c++)
      if (p[8*c +: 8] < lo[8*c +: 8] || p[8*c +: 8] > hi[8*c +: 8]) return 1'b0;
    return 1'b1;
  endfunction

  // Pixel i of a frame sits at (i % W, i / W); lines at or beyond H never count.
  function automatic void modelFrame(input logic [23:0] px[$]);
    int n, x, y;
    n = 0;
    mXmin = '0; mYmin = '0; mXmax = '0; mYmax = '0;
    foreach (px[i]) begin
      x = i % W;
      y = i / W;
      if (y < H && pixelMatches(px[i], curLo, curHi)) begin
        if (n == 0) begin
          mXmin = 11'(x); mXmax = 11'(x); mYmin = 11'(y); mYmax = 11'(y);
        end else begin
          if (11'(x) < mXmin) mXmin = 11'(x);
          if (11'(x) > mXmax) mXmax = 11'(x);
          if (11'(y) < mYmin) mYmin = 11'(y);
          if (11'(y) > mYmax) mYmax = 11'(y);
        end
        n++;
      end
    end
    mCount = 20'(n);
  endfunction

  task automatic applyStimulus(input logic [23:0] d, input logic s, input logic e, input bit withClear);
    bit taken;
    int budget;
    taken = 1'b0;
    budget = 0;
    sink_data = d; sink_sop = s; sink_eop = e; sink_valid = 1'b1;
    if (withClear) begin
      s_chipselect = 1'b1; s_write = 1'b1; s_address = 3'd0; s_writedata = 32'h2;
    end
    while (!taken && budget < 200) begin
      #1;
      taken = sink_ready;
      @(negedge clk);
      if (withClear) begin s_chipselect = 1'b0; s_write = 1'b0; end
      budget++;
    end
    sink_valid = 1'b0;
    if (!taken) begin
      checkOutput("accept_timeout", 32'h0, 32'h1);
    end else begin
      expQ.push_back({s, e, d});
      checkOutput("latency", {5'b0, source_valid, source_sop, source_eop, source_data},
                  {5'b0, 1'b1, s, e, d});
      if (randomReady && $urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  task automatic writeReg(input logic [2:0] a, input logic [31:0] d);
    s_chipselect = 1'b1; s_write = 1'b1; s_address = a; s_writedata = d;
    @(negedge clk);
    s_chipselect = 1'b0; s_write = 1'b0;
  endtask

  task automatic readReg(input logic [2:0] a, output logic [31:0] d);
    s_chipselect = 1'b1; s_read = 1'b1; s_address = a;
    @(negedge clk);
    s_chipselect = 1'b0; s_read = 1'b0;
    d = s_readdata;
  endtask

  task automatic writeLimits(input logic [23:0] lo, input logic [23:0] hi);
    writeReg(3'd4, {8'hA5, lo});
    writeReg(3'd5, {8'h5A, hi});
    curLo = lo;
    curHi = hi;
  endtask

  task automatic randomLimits();
    logic [23:0] lo, hi;
    int a, b;
    for (int c = 0; c < 3; c++) begin
      a = $urandom_range(0, 4);
      b = $urandom_range(a, 4);
      lo[8*c +: 8] = pal(a);
      hi[8*c +: 8] = pal(b);
    end
    writeLimits(lo, hi);
  endtask

  task automatic randomFrame(input int n);
    frame.delete();
    for (int i = 0; i < n; i++)
      frame.push_back({pal($urandom_range(0, 4)), pal($urandom_range(0, 4)), pal($urandom_range(0, 4))});
  endtask

  task automatic pulseReset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    expQ.delete();
  endtask

  task automatic sendVideoFrame(input logic [23:0] px[$], input bit withEop, input bit clearOnEop);
    applyStimulus(24'($urandom) & 24'hFFFFF0, 1'b1, 1'b0, 1'b0);
    foreach (px[i])
      applyStimulus(px[i], 1'b0, withEop && (i == px.size() - 1), clearOnEop && (i == px.size() - 1));
  endtask

  task automatic sendControl(input logic [3:0] kind, input int n);
    applyStimulus({20'($urandom), kind}, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) applyStimulus(24'($urandom), 1'b0, i == n - 1, 1'b0);
  endtask

  task automatic checkResults(input string tag);
    readReg(3'd0, rd); checkOutput({tag, "_status"}, rd, {16'(expFrames), 14'b0, expDone, mCount != 0});
    readReg(3'd1, rd); checkOutput({tag, "_bbox_min"}, rd, {5'b0, mYmin, 5'b0, mXmin});
    readReg(3'd2, rd); checkOutput({tag, "_bbox_max"}, rd, {5'b0, mYmax, 5'b0, mXmax});
    readReg(3'd3, rd); checkOutput({tag, "_count"}, rd, {12'b0, mCount});
    readReg(3'd4, rd); checkOutput({tag, "_lo"}, rd, {8'b0, curLo});
    readReg(3'd5, rd); checkOutput({tag, "_hi"}, rd, {8'b0, curHi});
  endtask

  task automatic drainStream();
    int budget;
    budget = 0;
    randomReady = 1'b0;
    while (expQ.size() != 0 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("drain_empty", 32'(expQ.size()), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    checkOutput("rst_source", {5'b0, source_valid, source_sop, source_eop, source_data}, 32'h0);
    checkOutput("rst_sink_ready", 32'(sink_ready), 32'h1);
    checkOutput("rst_readdata", s_readdata, 32'h0);
    mXmin = '0; mYmin = '0; mXmax = '0; mYmax = '0; mCount = '0;
    checkResults("rst");
    readReg(3'd6, rd); checkOutput("rst_id", rd, 32'h00BB0001);
    readReg(3'd7, rd); checkOutput("rst_addr7", rd, 32'h0);

    // Two red pixels in a 4x2 frame, one of them on the eop beat.
    writeLimits(24'hF00000, 24'hFF3030);
    frame = '{24'h0, 24'hFF0000, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'hFF0000};
    sendVideoFrame(frame, 1'b1, 1'b0);
    expFrames = 1; expDone = 1'b1; modelFrame(frame);
    readReg(3'd1, rd); checkOutput("t1_bbox_min", rd, 32'h00000001);
    readReg(3'd2, rd); checkOutput("t1_bbox_max", rd, 32'h00010003);
    readReg(3'd3, rd); checkOutput("t1_count", rd, 32'h00000002);
    readReg(3'd0, rd); checkOutput("t1_status", rd, 32'h00010003);
    applyStimulus(24'h000000, 1'b1, 1'b1, 1'b0);
    checkResults("sop_eop");

    randomReady = 1'b1;
    for (int f = 0; f < 12; f++) begin
      randomLimits();
      if ($urandom_range(0, 2) == 0) sendControl(4'($urandom_range(1, 15)), $urandom_range(1, 5));
      randomFrame($urandom_range(1, 4 * W));
      sendVideoFrame(frame, 1'b1, 1'b0);
      expFrames++; expDone = 1'b1; modelFrame(frame);
      checkResults("t2");
    end
    drainStream();

    pulseReset();
    expFrames = 0; expDone = 1'b0; curLo = 24'h000000; curHi = 24'hFFFFFF;
    writeLimits(24'h808080, 24'h808080);
    applyStimulus(24'h00000F, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(24'h808080, 1'b0, i == 2, 1'b0);
    readReg(3'd0, rd); checkOutput("t3_ctrl_status", rd, 32'h0);
    randomFrame(0);
    for (int i = 0; i < 8; i++) frame.push_back(24'h000000);
    sendVideoFrame(frame, 1'b1, 1'b0);
    expFrames = 1; expDone = 1'b1; modelFrame(frame);
    readReg(3'd0, rd); checkOutput("t3_status", rd, 32'h00010002);
    checkResults("t3");

    pulseReset();
    expFrames = 0; expDone = 1'b0; curLo = 24'h000000; curHi = 24'hFFFFFF;
    writeLimits(24'hF00000, 24'hFF3030);
    frame = '{24'hFF0000, 24'h0, 24'hFF0000};
    sendVideoFrame(frame, 1'b0, 1'b0);
    frame = '{24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'hFF0000, 24'hFF0000, 24'h0};
    sendVideoFrame(frame, 1'b1, 1'b0);
    expFrames = 1; expDone = 1'b1; modelFrame(frame);
    readReg(3'd1, rd); checkOutput("t4_bbox_min", rd, 32'h00010001);
    readReg(3'd2, rd); checkOutput("t4_bbox_max", rd, 32'h00010002);
    checkResults("t4");

    writeReg(3'd0, 32'h2);
    expDone = 1'b0;
    checkResults("t5_pre_clear");
    frame = '{24'hFF0000, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'hFF1010};
    sendVideoFrame(frame, 1'b1, 1'b1);
    expFrames = 2; expDone = 1'b1; modelFrame(frame);
    checkResults("t5_set_wins");
    writeReg(3'd0, 32'h2);
    expDone = 1'b0;
    checkResults("t5_cleared");
    writeReg(3'd1, 32'hFFFFFFFF);
    writeReg(3'd3, 32'hFFFFFFFF);
    writeReg(3'd6, 32'h12345678);
    checkResults("t5_ro_ignored");
    readReg(3'd6, rd); checkOutput("t5_id", rd, 32'h00BB0001);
    writeReg(3'd4, 32'hFFABCDEF);
    readReg(3'd4, rd); checkOutput("t5_lo_upper", rd, 32'h00ABCDEF);

    writeLimits(24'h101010, 24'hE0E0E0);
    applyStimulus(24'h000000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(24'h808080, 1'b0, 1'b0, 1'b0);
    pulseReset();
    expFrames = 0; expDone = 1'b0; curLo = 24'h000000; curHi = 24'hFFFFFF;
    mXmin = '0; mYmin = '0; mXmax = '0; mYmax = '0; mCount = '0;
    checkOutput("t6_source", {5'b0, source_valid, source_sop, source_eop, source_data}, 32'h0);
    checkOutput("t6_readdata", s_readdata, 32'h0);
    checkResults("t6_reset");
    for (int i = 0; i < 5; i++) applyStimulus(24'h808080, 1'b0, i == 4, 1'b0);
    checkResults("t6_tail_ignored");
    randomFrame(8);
    sendVideoFrame(frame, 1'b1, 1'b0);
    expFrames = 1; expDone = 1'b1; modelFrame(frame);
    checkResults("t6_after");
    drainStream();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bbox_tracker.md
BBOX_TRACKER -- requirements
Module: bbox_tracker

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- IMAGE_W, 640, active pixels per line.
- IMAGE_H, 480, active lines per frame.
REQ-002 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 reset_n  in  1  reset, synchronous and active-low.
REQ-004 sink_data  in  24  RGB pixel {R[23:16],G[15:8],B[7:0]}, or packet header on the sop beat.
REQ-005 sink_valid, sink_sop, sink_eop  in  1 each  upstream Avalon-ST qualifiers.
REQ-006 sink_ready  out  1  accept indication to upstream.
REQ-007 source_data  out  24; source_valid, source_sop, source_eop  out  1 each  pass-through stream.
REQ-008 source_ready  in  1  downstream backpressure.
REQ-009 s_chipselect, s_read, s_write  in  1 each; s_address  in  3; s_writedata  in  32; s_readdata  out  32  Avalon-MM slave.

Function
REQ-010 Beat transfer: a sink beat SHALL be accepted when sink_valid && sink_ready; a source beat SHALL complete when source_valid && source_ready.
REQ-011 Pass-through: single-entry register slice; sink_ready = source_ready || !source_valid; accepted beats SHALL appear on source_* exactly 1 cycle later, with data, sop and eop unmodified.
REQ-012 No beat SHALL be dropped, duplicated or reordered under any backpressure pattern.
REQ-013 Parser FSM states are WAIT_SOP, VIDEO and OTHER; the FSM SHALL advance only on accepted beats.
REQ-014 Any accepted sop beat SHALL select the next state from header bits [3:0]: 0 -> VIDEO, otherwise -> OTHER.
REQ-015 A sop beat SHALL also clear x, y and the per-frame accumulators, including when a frame is in progress (truncated frame is discarded with no result update).
REQ-016 An accepted eop beat SHALL return the FSM to WAIT_SOP; a beat carrying both sop and eop SHALL produce no result update.
REQ-017 In VIDEO, each accepted non-sop beat is pixel (x,y); x and y are 11-bit counters.
REQ-018 After each pixel, x SHALL increment; at x == IMAGE_W-1, x SHALL wrap to 0 and y SHALL increment.
REQ-019 Pixels with y >= IMAGE_H SHALL be passed through but SHALL NOT be evaluated.
REQ-020 A pixel matches when LO.ch <= ch <= HI.ch holds for each of R, G and B, compared unsigned 8-bit.
REQ-021 On each matching pixel, xmin, ymin, xmax and ymax SHALL update, and the 20-bit match count SHALL increment, saturating at 0xFFFFF.
REQ-022 Accepted eop in VIDEO (not on the sop beat) SHALL copy the accumulators into the result registers on the same edge.
REQ-023 That same edge SHALL set done, increment the 16-bit frame count (wrapping), and set hit = (match count != 0).
REQ-024 If hit = 0, result bbox registers SHALL read 0.
REQ-025 Register map, with reads registered so s_readdata is valid 1 cycle after s_chipselect && s_read:
- 0 STATUS (R): {frame_count[15:0], 14'b0, done, hit}; writing 1 to bit1 clears done.
- 1 BBOX_MIN (R): {5'b0, ymin, 5'b0, xmin}.
- 2 BBOX_MAX (R): {5'b0, ymax, 5'b0, xmax}.
- 3 COUNT (R): {12'b0, count[19:0]}.
- 4 LO (RW): [23:0] lower bound.
- 5 HI (RW): [23:0] upper bound.
- 6 ID (R): 0x00BB0001.
- 7: reads 0.
REQ-026 Writes to read-only addresses SHALL be ignored; the bits [31:24] of LO and HI SHALL read 0.
REQ-027 If a done-clear write coincides with a frame-end update, the set SHALL win.
REQ-028 A LO/HI write SHALL take effect for pixels accepted from the next cycle on, including pixels within the current frame.

Reset
REQ-029 With reset_n low at a clock edge, the following SHALL be cleared: source_valid, source_sop, source_eop and source_data = 0; FSM = WAIT_SOP; x, y and accumulators = 0.
REQ-030 Reset SHALL also clear: result registers, hit, done and frame count = 0; LO = 0x000000; HI = 0xFFFFFF; s_readdata = 0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame; the following beats up to the next sop SHALL be passed through and ignored.

Verification
REQ-032 Test 1: 4x2 frame (IMAGE_W=4, IMAGE_H=2), LO=0xF00000, HI=0xFF3030, red pixel 0xFF0000 at (1,0) and (3,1), others 0 -> BBOX_MIN=0x00000001, BBOX_MAX=0x00010003, COUNT=2, STATUS=0x00010003.
REQ-033 Test 2: random source_ready (50%) over a 640x480 random frame -> source sequence identical to the sink sequence; latency 1 cycle when unstalled.
REQ-034 Test 3: control packet (header 0xF) then video frame with no matches -> frame_count=1, hit=0, BBOX regs 0.
REQ-035 Test 4: sop arrives mid-frame without eop, then a full frame -> only the second frame is reported; frame_count=1.
REQ-036 Test 5: write STATUS=0x2 in the same cycle as the eop acceptance -> done reads 1; a later write of 0x2 -> done reads 0.
REQ-037 Test 6: reset_n low for 1 cycle mid-frame -> all outputs and registers at reset values next cycle; LO/HI read 0x000000/0xFFFFFF.
